// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: multi-cycle unsigned multiplier holding the architectural HI/LO pair.
// A MULTU issued with start is computed radix-2 shift-add, one multiplier bit per cycle,
// and {hi,lo} is written once, when the last bit has been consumed.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-low reset
//   start   in   issue MULTU (accepted only when idle)
//   cancel  in   pipeline flush, aborts an in-flight multiply
//   src_a   in   multiplicand, latched with start
//   src_b   in   multiplier, latched with start
//   busy    out  multiply in flight
//   done    out  one-cycle pulse after hi/lo take a new product
//   hi      out  upper half of the last completed product
//   lo      out  lower half of the last completed product
module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Partial-product add; the extra top bit keeps the carry that the shift brings back into acc.
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   acc_next_c;
  logic [WIDTH-1:0]   mplier_next_c;

  always_comb begin
    sum_c         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH + 1)'(0));
    acc_next_c    = sum_c[WIDTH:1];
    mplier_next_c = {sum_c[0], mplier_q[WIDTH-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        // cancel has no effect while idle, so a start alongside it is still taken.
        if (start) begin
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (cancel) begin
          // Abort wins even on the final step; hi/lo keep the previous product.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d    = acc_next_c;
          mplier_d = mplier_next_c;
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = acc_next_c;
            lo_d    = mplier_next_c;
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed and randomized MULTU sequences checked against an
// arithmetic reference (64-bit product, HI/LO only updated on a completed multiply).
module tb_multu_hilo_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cancel;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec;
  int n_err;

  // Architectural reference: last completed product.
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cancel (cancel),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_regs(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  // One MULTU issue. cancel_at / rst_at / intrude_at name the RUN edge (1..W) at which the
  // event is sampled, 0 = never. b2b leaves the bench in the done cycle for a back-to-back issue.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int cancel_at, input int rst_at, input int intrude_at,
                        input bit idle_cancel, input bit b2b, input string tag);
    logic [63:0] prod;
    bit          saw_done;
    prod   = 64'(a) * 64'(b);
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    cancel = idle_cancel;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    src_a  = $urandom;
    src_b  = $urandom;
    for (int k = 1; k <= int'(W); k++) begin
      chk({tag, ".busy_run"}, 64'(busy), 64'(1));
      chk({tag, ".done_run"}, 64'(done), 64'(0));
      if (k == intrude_at) begin
        start = 1'b1;
        src_a = 32'd3;
        src_b = 32'd3;
      end
      if (k == cancel_at) cancel = 1'b1;
      if (k == rst_at) rst = 1'b0;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      if (k == rst_at) begin
        tick();
        rst    = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        chk_idle_regs({tag, ".after_rst"});
        return;
      end
      if (k == cancel_at) begin
        saw_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (done) saw_done = 1'b1;
          tick();
        end
        if (done) saw_done = 1'b1;
        chk({tag, ".cancel_no_done"}, 64'(saw_done), 64'(0));
        chk_idle_regs({tag, ".after_cancel"});
        return;
      end
    end
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    chk({tag, ".done_pulse"}, 64'(done), 64'(1));
    chk({tag, ".busy_end"}, 64'(busy), 64'(0));
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    if (!b2b) begin
      tick();
      chk_idle_regs({tag, ".post"});
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    exp_hi = '0;
    exp_lo = '0;
    rst    = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    src_a  = '0;
    src_b  = '0;
    tick();
    tick();
    rst = 1'b1;
    chk_idle_regs("reset");

    // Reset two edges in the middle of a multiply.
    run_op(32'd11, 32'd13, 0, 3, 0, 1'b0, 1'b0, "rst_mid");
    run_op(32'd7, 32'd6, 0, 0, 0, 1'b0, 1'b0, "7x6");
    run_op(32'd5, 32'd5, 10, 0, 0, 1'b0, 1'b0, "cancel_t10");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0, "max_sq");
    run_op(32'h8000_0000, 32'd2, 0, 0, 5, 1'b0, 1'b0, "ignore_start");
    run_op(32'd9, 32'd9, 0, 15, 0, 1'b0, 1'b0, "rst_t15");
    run_op(32'd3, 32'd4, 0, 0, 0, 1'b0, 1'b0, "3x4");
    // cancel on the final edge beats completion
    run_op(32'd1234, 32'd5678, int'(W), 0, 0, 1'b0, 1'b0, "cancel_last");
    // start together with cancel while idle is accepted
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 0, 1'b1, 1'b0, "idle_cancel");
    // start in the done cycle, then a second back-to-back
    run_op(32'h0001_0000, 32'h0001_0000, 0, 0, 0, 1'b0, 1'b1, "b2b_a");
    run_op(32'hCAFE_F00D, 32'd0, 0, 0, 0, 1'b0, 1'b1, "b2b_b");
    run_op(32'd0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0, "b2b_c");

    for (int i = 0; i < 20; i++) begin
      int c;
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      run_op($urandom, $urandom, c, 0, int'($urandom_range(0, W)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
